osd_regaccess_master: RTL and testbench
=======================================

# osd_regaccess_master

Initiator side of the OSD register-access protocol. It turns a simple local request (read or write of one 16-bit register in a remote debug module) into a DII request packet, then waits for the matching response packet and returns read data or an error status. It sits between a local controller (host interface, debug processor firmware port) and the debug interconnect. It issues packets to any module built on the register-access responder layer.

## Interface
- `TIMEOUT`, default 1024: response timeout in clk cycles. Used only with `OSD_REGACCESS_MASTER_TIMEOUT_EN`. Must be ≥ 2.
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: synchronous, active-high reset.
- `id` input, 16 bits: own DII address, placed in the src word.
- `req_valid` input, 1 bit: request valid.
- `req_ready` output, 1 bit: request accepted when high together with `req_valid`.
- `req_write` input, 1 bit: 1 = write, 0 = read.
- `req_dest` input, 16 bits: target module address.
- `req_addr` input, 16 bits: register address.
- `req_wdata` input, 16 bits: write data.
- `resp_valid` output, 1 bit: one-cycle completion pulse.
- `resp_err` output, 1 bit: error or timeout. Valid with `resp_valid`.
- `resp_timeout` output, 1 bit: completion caused by timeout. Valid with `resp_valid`.
- `resp_rdata` output, 16 bits: read data. Valid with `resp_valid` on a read success.
- `debug_out` output, dii_flit: outgoing flit, carrying data[15:0], valid and last.
- `debug_out_ready` input, 1 bit: interconnect accepts `debug_out`.
- `debug_in` input, dii_flit: incoming flit.
- `debug_in_ready` output, 1 bit: block accepts `debug_in`.

## Operation
- Packet word order is dest, src, flags, then payload. The flags word is laid out as type[15:14], type_sub[13:10], with 0 in bits [9:0]. Register access uses type = 2'b00.
- type_sub encodings:
  - 0: read request, 16-bit.
  - 4: write request, 16-bit.
  - 8: read success, 16-bit.
  - 12: read error.
  - 13: write success.
  - 14: write error.
- Request packets sent:
  - Read: req_dest, id, 16'h0000, req_addr. last is set on req_addr (4 flits).
  - Write: req_dest, id, 16'h1000, req_addr, req_wdata. last is set on req_wdata (5 flits).
- Request fields are captured into registers on acceptance. The inputs may change afterwards.
- FSM states: IDLE, TX_DEST, TX_SRC, TX_FLAGS, TX_ADDR, TX_DATA, RX_DEST, RX_SRC, RX_FLAGS, RX_DATA, RX_DRAIN, DONE.
- Transmit path:
  - IDLE → TX_DEST on request acceptance.
  - Each TX state advances only on `debug_out.valid && debug_out_ready`.
  - TX_ADDR goes to TX_DATA for a write, or to RX_DEST for a read.
  - TX_DATA goes to RX_DEST.
- Receive path:
  - RX_DEST: accepts a flit. Dest ≠ id → RX_DRAIN.
  - RX_SRC: src ≠ captured dest → RX_DRAIN.
  - RX_FLAGS checks the type_sub against the request kind:
    - Read with type_sub 8 → RX_DATA.
    - Read with type_sub 12 → DONE, err = 1.
    - Write with type_sub 13 → DONE, err = 0.
    - Write with type_sub 14 → DONE, err = 1.
    - Anything else → RX_DRAIN.
  - RX_DATA captures `resp_rdata` → DONE.
  - RX_DRAIN discards flits up to and including last, then returns to RX_DEST. Discarded packets are not completions.
- A flit with last set before the packet is complete (an early-last) returns the FSM to RX_DEST. The one exception is that an early-last on a valid error or write response is a normal end.
- A response packet longer than expected is drained to last before DONE.
- DONE lasts one cycle: `resp_valid` = 1, then → IDLE.
- Only one transaction is outstanding at a time. `req_ready` = 1 only in IDLE.
- `debug_in_ready` = 1 in every state when not in reset. Flits arriving in IDLE or TX states are discarded, with packet-boundary tracking so that a later RX_DEST starts on a packet head.

## Timing
- Reset values:
  - State = IDLE.
  - `req_ready` = 0 during rst, 1 after.
  - `debug_out.valid` = 0, `debug_out.last` = 0, `debug_out.data` = 0.
  - `debug_in_ready` = 0 during rst.
  - `resp_valid` = 0, `resp_err` = 0, `resp_timeout` = 0, `resp_rdata` = 0.
- Latency:
  - Request accepted in cycle 0; dest flit is valid in cycle 1.
  - With `debug_out_ready` held high, a read's last flit goes in cycle 4.
  - `resp_valid` asserts the cycle after the last needed response flit is accepted.
- `debug_out.valid`, once asserted, holds with stable data until accepted.
- `rst` mid-transaction: the FSM aborts to IDLE next cycle with no `resp_valid`. Any partially sent packet is truncated.

## Configuration
- `OSD_REGACCESS_MASTER_TIMEOUT_EN` defined:
  - A counter loads `TIMEOUT` when the last request flit is accepted and decrements in all RX states.
  - Reaching 0 forces DONE with `resp_err` = 1 and `resp_timeout` = 1.
  - A response arriving later is discarded by the IDLE-drain logic.
- Not defined: no counter. The block waits indefinitely and `resp_timeout` is tied to 0.

## Test plan
- Read (id = 1, dest = 5, addr = 0x200), response 1,5,0x2000,0x0040 → tx 5,1,0x0000,0x0200 (last on 0x0200); resp_valid, err = 0, rdata = 0x0040.
- Write (addr = 0x3, data = 0xBEEF), response 1,5,0x3400 → tx 5 flits ending 0xBEEF; resp_valid, err = 0. Response flags 0x3800 instead → err = 1.
- Read with `debug_out_ready` toggling 1/0 each cycle → flits are never dropped or duplicated; data stays stable while stalled.
- Foreign packet (src = 7, 6 flits) arrives before the real response → it is drained and ignored; the real response then completes normally.
- Timeout build with TIMEOUT = 16 and no response → resp_valid 16 cycles after the last tx flit, err = 1, timeout = 1. Non-timeout build → no resp_valid after 1000 cycles.
- rst asserted during TX_FLAGS → next cycle IDLE, `req_ready` = 1 after release, `debug_out.valid` = 0, no resp_valid.

Source files
------------

// File: rtl/osd_regaccess_master.sv
// -----------------------------------------------------------------------------
// osd_regaccess_master
//
// Initiator side of the OSD register-access protocol. A local read/write
// request for one 16-bit register in a remote debug module is turned into a
// DII request packet. The block then waits for the matching response packet
// and returns read data or an error status.
//
// Build option:
//   OSD_REGACCESS_MASTER_TIMEOUT_EN - when defined, a response timeout of
//   TIMEOUT clk cycles is armed once the last request flit is accepted.
//   When undefined, the block waits for a response indefinitely.
//
// Ports:
//   clk, rst          - single clock, synchronous active-high reset
//   id                - own DII address (src word of requests)
//   req_*             - local request channel (valid/ready)
//   resp_*            - one-cycle completion pulse with status and read data
//   debug_out(_ready) - outgoing DII flits (valid/ready)
//   debug_in(_ready)  - incoming DII flits (valid/ready)
//   dbg_state         - current FSM state, for observation only
//
// Handshake rule for every channel: a transfer happens in a cycle where both
// valid and ready are high; a raised valid stays high with stable payload
// until that transfer happens.
// -----------------------------------------------------------------------------
package osd_regaccess_master_pkg;
   typedef struct packed {
      logic [15:0] data;
      logic        last;
      logic        valid;
   } dii_flit;
endpackage

module osd_regaccess_master
   import osd_regaccess_master_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] id,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_dest,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic        resp_timeout,
   output logic [15:0] resp_rdata,
   output dii_flit     debug_out,
   input  logic        debug_out_ready,
   input  dii_flit     debug_in,
   output logic        debug_in_ready,
   output logic [3:0]  dbg_state
);

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      TX_DEST  = 4'd1,
      TX_SRC   = 4'd2,
      TX_FLAGS = 4'd3,
      TX_ADDR  = 4'd4,
      TX_DATA  = 4'd5,
      RX_DEST  = 4'd6,
      RX_SRC   = 4'd7,
      RX_FLAGS = 4'd8,
      RX_DATA  = 4'd9,
      RX_DRAIN = 4'd10,
      DONE     = 4'd11
   } state_t;

   state_t      r_state;
   logic        r_write;
   logic [15:0] r_dest;
   logic [15:0] r_addr;
   logic [15:0] r_wdata;
   dii_flit     r_out;
   logic        r_resp_valid;
   logic        r_resp_err;
   logic        r_resp_timeout;
   logic [15:0] r_resp_rdata;
   // Set while an incoming packet is mid-flight outside the RX states, so
   // the receive path starts on a packet head.
   logic        r_in_mid;
   // A valid completion was recognised but the packet still has trailing
   // flits; the completion is reported once they are drained.
   logic        r_pend;
   logic        r_pend_err;

   logic        w_out_fire;
   logic        w_is_rx;
   logic        w_in_mid_nxt;
   logic        w_mid_at_tmo;
   logic        w_type_ok;
   logic [3:0]  w_sub;
   logic        w_rd_ok;
   logic        w_cpl;
   logic        w_cpl_err;
   logic        w_tmo_hit;

   assign w_out_fire   = r_out.valid && debug_out_ready;
   assign w_is_rx      = (r_state == RX_DEST) || (r_state == RX_SRC) ||
                         (r_state == RX_FLAGS) || (r_state == RX_DATA) ||
                         (r_state == RX_DRAIN);
   assign w_in_mid_nxt = debug_in.valid ? !debug_in.last : r_in_mid;
   // Packet position after this cycle if a timeout cuts the RX path short.
   assign w_mid_at_tmo = debug_in.valid ? !debug_in.last : (r_state != RX_DEST);

   // Response flags word decode: type[15:14], type_sub[13:10].
   assign w_type_ok = (debug_in.data[15:14] == 2'b00);
   assign w_sub     = debug_in.data[13:10];
   assign w_rd_ok   = w_type_ok && !r_write && (w_sub == 4'd8);
   assign w_cpl     = w_type_ok &&
                      ((!r_write && (w_sub == 4'd12)) ||
                       (r_write && ((w_sub == 4'd13) || (w_sub == 4'd14))));
   assign w_cpl_err = (w_sub != 4'd13);

`ifdef OSD_REGACCESS_MASTER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT) + 1;
   logic [TMO_W-1:0] r_tmo;

   // The load cycle counts as the first cycle of the budget, so the
   // completion appears exactly TIMEOUT cycles after the last request flit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tmo <= '0;
      end else if (w_out_fire && r_out.last) begin
         r_tmo <= TMO_W'(TIMEOUT - 1);
      end else if (w_is_rx && (r_tmo != '0)) begin
         r_tmo <= r_tmo - TMO_W'(1);
      end
   end

   assign w_tmo_hit = w_is_rx && (r_tmo == TMO_W'(1));
`else
   assign w_tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= IDLE;
         r_write        <= 1'b0;
         r_dest         <= '0;
         r_addr         <= '0;
         r_wdata        <= '0;
         r_out          <= '0;
         r_resp_valid   <= 1'b0;
         r_resp_err     <= 1'b0;
         r_resp_timeout <= 1'b0;
         r_resp_rdata   <= '0;
         r_in_mid       <= 1'b0;
         r_pend         <= 1'b0;
         r_pend_err     <= 1'b0;
      end else begin
         r_resp_valid <= 1'b0;
         // Outside RX, incoming flits are discarded but packet edges tracked.
         if (!w_is_rx && debug_in.valid) begin
            r_in_mid <= !debug_in.last;
         end

         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_write    <= req_write;
                  r_dest     <= req_dest;
                  r_addr     <= req_addr;
                  r_wdata    <= req_wdata;
                  r_pend     <= 1'b0;
                  r_out      <= '{data: req_dest, last: 1'b0, valid: 1'b1};
                  r_state    <= TX_DEST;
               end
            end
            TX_DEST: begin
               if (w_out_fire) begin
                  r_out.data <= id;
                  r_state    <= TX_SRC;
               end
            end
            TX_SRC: begin
               if (w_out_fire) begin
                  r_out.data <= r_write ? 16'h1000 : 16'h0000;
                  r_state    <= TX_FLAGS;
               end
            end
            TX_FLAGS: begin
               if (w_out_fire) begin
                  r_out.data <= r_addr;
                  r_out.last <= !r_write;
                  r_state    <= TX_ADDR;
               end
            end
            TX_ADDR: begin
               if (w_out_fire) begin
                  if (r_write) begin
                     r_out.data <= r_wdata;
                     r_out.last <= 1'b1;
                     r_state    <= TX_DATA;
                  end else begin
                     r_out    <= '0;
                     r_in_mid <= 1'b0;
                     r_state  <= w_in_mid_nxt ? RX_DRAIN : RX_DEST;
                  end
               end
            end
            TX_DATA: begin
               if (w_out_fire) begin
                  r_out    <= '0;
                  r_in_mid <= 1'b0;
                  r_state  <= w_in_mid_nxt ? RX_DRAIN : RX_DEST;
               end
            end
            RX_DEST: begin
               // A single-flit packet (last on dest) leaves us on a head.
               if (debug_in.valid && !debug_in.last) begin
                  r_state <= (debug_in.data != id) ? RX_DRAIN : RX_SRC;
               end
            end
            RX_SRC: begin
               if (debug_in.valid) begin
                  if (debug_in.last) begin
                     r_state <= RX_DEST;
                  end else begin
                     r_state <= (debug_in.data != r_dest) ? RX_DRAIN : RX_FLAGS;
                  end
               end
            end
            RX_FLAGS: begin
               if (debug_in.valid) begin
                  if (w_rd_ok) begin
                     r_state <= debug_in.last ? RX_DEST : RX_DATA;
                  end else if (w_cpl) begin
                     if (debug_in.last) begin
                        r_resp_valid   <= 1'b1;
                        r_resp_err     <= w_cpl_err;
                        r_resp_timeout <= 1'b0;
                        r_in_mid       <= 1'b0;
                        r_state        <= DONE;
                     end else begin
                        r_pend     <= 1'b1;
                        r_pend_err <= w_cpl_err;
                        r_state    <= RX_DRAIN;
                     end
                  end else begin
                     r_state <= debug_in.last ? RX_DEST : RX_DRAIN;
                  end
               end
            end
            RX_DATA: begin
               if (debug_in.valid) begin
                  r_resp_rdata <= debug_in.data;
                  if (debug_in.last) begin
                     r_resp_valid   <= 1'b1;
                     r_resp_err     <= 1'b0;
                     r_resp_timeout <= 1'b0;
                     r_in_mid       <= 1'b0;
                     r_state        <= DONE;
                  end else begin
                     r_pend     <= 1'b1;
                     r_pend_err <= 1'b0;
                     r_state    <= RX_DRAIN;
                  end
               end
            end
            RX_DRAIN: begin
               if (debug_in.valid && debug_in.last) begin
                  if (r_pend) begin
                     r_resp_valid   <= 1'b1;
                     r_resp_err     <= r_pend_err;
                     r_resp_timeout <= 1'b0;
                     r_in_mid       <= 1'b0;
                     r_state        <= DONE;
                  end else begin
                     r_state <= RX_DEST;
                  end
               end
            end
            DONE: begin
               r_pend  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase

         // Timeout overrides whatever the RX path decided this cycle.
         if (w_tmo_hit) begin
            r_resp_valid   <= 1'b1;
            r_resp_err     <= 1'b1;
            r_resp_timeout <= 1'b1;
            r_in_mid       <= w_mid_at_tmo;
            r_state        <= DONE;
         end
      end
   end

   assign req_ready      = (r_state == IDLE) && !rst;
   assign debug_in_ready = !rst;
   assign debug_out      = r_out;
   assign resp_valid     = r_resp_valid;
   assign resp_err       = r_resp_err;
   assign resp_timeout   = r_resp_timeout;
   assign resp_rdata     = r_resp_rdata;
   assign dbg_state      = r_state;

endmodule

// File: tb/tb_osd_regaccess_master.sv
module tb_osd_regaccess_master;
  import osd_regaccess_master_pkg::*;

  localparam logic [15:0] ID = 16'h0001;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_dest = '0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic        resp_timeout;
  logic [15:0] resp_rdata;
  dii_flit     debug_out;
  logic        debug_out_ready = 1'b1;
  dii_flit     debug_in = '0;
  logic        debug_in_ready;
  logic [3:0]  dbg_state;

  osd_regaccess_master #(.TIMEOUT(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .id             (ID),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_dest       (req_dest),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_err       (resp_err),
    .resp_timeout   (resp_timeout),
    .resp_rdata     (resp_rdata),
    .debug_out      (debug_out),
    .debug_out_ready(debug_out_ready),
    .debug_in       (debug_in),
    .debug_in_ready (debug_in_ready),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [16:0] tx_exp_q[$];    // {last, data}
  logic [18:0] resp_exp_q[$];  // {check_rdata, err, timeout, rdata}
  logic [16:0] e_tx;
  logic [18:0] e_rs;
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_tx_cyc = 0;
  int last_in_cyc = 0;
  int last_resp_cyc = 0;
  int resp_seen = 0;
  logic stall_mode = 1'b0;
  logic prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic prev_last = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Output-ready driver: steady high, or toggling every cycle in stall mode.
  initial forever begin
    @(posedge clk);
    #1;
    debug_out_ready = stall_mode ? ~debug_out_ready : 1'b1;
  end

  // Monitor: samples on the falling edge, pops and compares expectations.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_cmp++;
        if (debug_out.valid !== 1'b1 || debug_out.data !== prev_data || debug_out.last !== prev_last) begin
          n_bad++;
          $display("FAIL tx_stable: got valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   debug_out.valid, debug_out.data, debug_out.last, prev_data, prev_last);
        end
      end
      if (debug_out.valid && debug_out_ready) begin
        n_cmp++;
        if (tx_exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL tx_flit: unexpected flit data=%h last=%b", debug_out.data, debug_out.last);
        end else begin
          e_tx = tx_exp_q.pop_front();
          if ({debug_out.last, debug_out.data} !== e_tx) begin
            n_bad++;
            $display("FAIL tx_flit: got last=%b data=%h, required last=%b data=%h",
                     debug_out.last, debug_out.data, e_tx[16], e_tx[15:0]);
          end
        end
        if (debug_out.last) last_tx_cyc = cyc;
      end
      if (resp_valid) begin
        resp_seen++;
        last_resp_cyc = cyc;
        n_cmp++;
        if (resp_exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL resp: unexpected completion err=%b timeout=%b rdata=%h", resp_err, resp_timeout, resp_rdata);
        end else begin
          e_rs = resp_exp_q.pop_front();
          if (resp_err !== e_rs[17] || resp_timeout !== e_rs[16] || (e_rs[18] && resp_rdata !== e_rs[15:0])) begin
            n_bad++;
            $display("FAIL resp: got err=%b timeout=%b rdata=%h, required err=%b timeout=%b rdata=%h (rdata checked=%b)",
                     resp_err, resp_timeout, resp_rdata, e_rs[17], e_rs[16], e_rs[15:0], e_rs[18]);
          end
        end
      end
      prev_stall = debug_out.valid && !debug_out_ready;
      prev_data  = debug_out.data;
      prev_last  = debug_out.last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_resp(input logic chk, input logic err, input logic tmo, input logic [15:0] rdata);
    resp_exp_q.push_back({chk, err, tmo, rdata});
  endtask

  task automatic do_request(input logic wr, input logic [15:0] dest, input logic [15:0] addr, input logic [15:0] wdata);
    int g = 0;
    while (!req_ready && g < 50) begin
      tick();
      g++;
    end
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL req_ready_wait: got %b after %0d cycles, required 1", req_ready, g);
    end
    tx_exp_q.push_back({1'b0, dest});
    tx_exp_q.push_back({1'b0, ID});
    tx_exp_q.push_back({1'b0, (wr ? 16'h1000 : 16'h0000)});
    tx_exp_q.push_back({~wr, addr});
    if (wr) tx_exp_q.push_back({1'b1, wdata});
    req_valid = 1'b1;
    req_write = wr;
    req_dest  = dest;
    req_addr  = addr;
    req_wdata = wdata;
    acc_cyc   = cyc;
    tick();
    // Scramble the request fields: the packet must use the captured copy.
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_dest  = 16'($urandom_range(0, 65535));
    req_addr  = 16'($urandom_range(0, 65535));
    req_wdata = 16'($urandom_range(0, 65535));
  endtask

  task automatic wait_tx(input int max);
    int g = 0;
    while (tx_exp_q.size() != 0 && g < max) begin
      tick();
      g++;
    end
    n_cmp++;
    if (tx_exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL tx_done: %0d flits still outstanding after %0d cycles, required 0", tx_exp_q.size(), g);
      tx_exp_q.delete();
    end
  endtask

  task automatic send_pkt(input int n, input logic with_last,
                          input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                          input logic [15:0] w3, input logic [15:0] w4, input logic [15:0] w5);
    logic [15:0] w [6];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3; w[4] = w4; w[5] = w5;
    for (int i = 0; i < n; i++) begin
      debug_in.valid = 1'b1;
      debug_in.data  = w[i];
      debug_in.last  = with_last && (i == n - 1);
      if (with_last && (i == n - 1)) last_in_cyc = cyc;
      tick();
    end
    debug_in = '0;
  endtask

  task automatic wait_resp(input int max);
    int g = 0;
    while (resp_exp_q.size() != 0 && g < max) begin
      tick();
      g++;
    end
    n_cmp++;
    if (resp_exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL resp_wait: %0d completions missing after %0d cycles, required 0", resp_exp_q.size(), g);
      resp_exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (req_ready !== 1'b0 || debug_in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ready: got req_ready=%b debug_in_ready=%b, required 0 0", req_ready, debug_in_ready);
    end
    n_cmp++;
    if (debug_out !== 18'h0) begin
      n_bad++;
      $display("FAIL reset_debug_out: got %h, required 0", debug_out);
    end
    n_cmp++;
    if ({resp_valid, resp_err, resp_timeout, resp_rdata} !== 19'h0) begin
      n_bad++;
      $display("FAIL reset_resp: got valid=%b err=%b tmo=%b rdata=%h, required all 0",
               resp_valid, resp_err, resp_timeout, resp_rdata);
    end
    n_cmp++;
    if (dbg_state !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %0d, required 0", dbg_state);
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (req_ready !== 1'b1 || debug_in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL after_reset_ready: got req_ready=%b debug_in_ready=%b, required 1 1", req_ready, debug_in_ready);
    end
  endtask

  task automatic test_read();
    do_request(1'b0, 16'h0005, 16'h0200, 16'h0000);
    push_resp(1'b1, 1'b0, 1'b0, 16'h0040);
    wait_tx(20);
    n_cmp++;
    if (last_tx_cyc - acc_cyc !== 4) begin
      n_bad++;
      $display("FAIL read_tx_latency: got %0d cycles, required 4", last_tx_cyc - acc_cyc);
    end
    send_pkt(4, 1'b1, ID, 16'h0005, 16'h2000, 16'h0040, 16'h0, 16'h0);
    wait_resp(10);
    n_cmp++;
    if (last_resp_cyc - last_in_cyc !== 1) begin
      n_bad++;
      $display("FAIL read_resp_latency: got %0d cycles, required 1", last_resp_cyc - last_in_cyc);
    end
  endtask

  task automatic test_write();
    do_request(1'b1, 16'h0005, 16'h0003, 16'hBEEF);
    push_resp(1'b0, 1'b0, 1'b0, 16'h0);
    wait_tx(20);
    send_pkt(3, 1'b1, ID, 16'h0005, 16'h3400, 16'h0, 16'h0, 16'h0);
    wait_resp(10);
    do_request(1'b1, 16'h0005, 16'h0003, 16'hBEEF);
    push_resp(1'b0, 1'b1, 1'b0, 16'h0);
    wait_tx(20);
    send_pkt(3, 1'b1, ID, 16'h0005, 16'h3800, 16'h0, 16'h0, 16'h0);
    wait_resp(10);
  endtask

  task automatic test_read_err();
    do_request(1'b0, 16'h0005, 16'h0010, 16'h0);
    push_resp(1'b0, 1'b1, 1'b0, 16'h0);
    wait_tx(20);
    send_pkt(3, 1'b1, ID, 16'h0005, 16'h3000, 16'h0, 16'h0, 16'h0);
    wait_resp(10);
  endtask

  task automatic test_stall();
    logic [15:0] a;
    logic [15:0] d;
    a = 16'($urandom_range(0, 65535));
    d = 16'($urandom_range(0, 65535));
    stall_mode = 1'b1;
    do_request(1'b0, 16'h0005, a, 16'h0);
    push_resp(1'b1, 1'b0, 1'b0, d);
    wait_tx(40);
    stall_mode = 1'b0;
    send_pkt(4, 1'b1, ID, 16'h0005, 16'h2000, d, 16'h0, 16'h0);
    wait_resp(10);
  endtask

  task automatic test_foreign();
    int base;
    do_request(1'b0, 16'h0005, 16'h0020, 16'h0);
    wait_tx(20);
    base = resp_seen;
    send_pkt(6, 1'b1, ID, 16'h0007, 16'h2000, 16'h1111, 16'h2222, 16'h3333);
    repeat (3) tick();
    n_cmp++;
    if (resp_seen !== base) begin
      n_bad++;
      $display("FAIL foreign_ignored: got %0d completions, required 0", resp_seen - base);
    end
    push_resp(1'b1, 1'b0, 1'b0, 16'h5A5A);
    send_pkt(4, 1'b1, ID, 16'h0005, 16'h2000, 16'h5A5A, 16'h0, 16'h0);
    wait_resp(10);
  endtask

  task automatic test_early_last();
    int base;
    do_request(1'b0, 16'h0005, 16'h0030, 16'h0);
    wait_tx(20);
    base = resp_seen;
    send_pkt(3, 1'b1, ID, 16'h0005, 16'h2000, 16'h0, 16'h0, 16'h0);
    repeat (3) tick();
    n_cmp++;
    if (resp_seen !== base) begin
      n_bad++;
      $display("FAIL early_last_ignored: got %0d completions, required 0", resp_seen - base);
    end
    push_resp(1'b1, 1'b0, 1'b0, 16'hC3C3);
    send_pkt(4, 1'b1, ID, 16'h0005, 16'h2000, 16'hC3C3, 16'h0, 16'h0);
    wait_resp(10);
  endtask

  task automatic test_long_resp();
    do_request(1'b1, 16'h0005, 16'h0040, 16'h1234);
    push_resp(1'b0, 1'b0, 1'b0, 16'h0);
    wait_tx(20);
    send_pkt(5, 1'b1, ID, 16'h0005, 16'h3400, 16'hDEAD, 16'hBEEF, 16'h0);
    wait_resp(10);
    n_cmp++;
    if (last_resp_cyc - last_in_cyc !== 1) begin
      n_bad++;
      $display("FAIL long_resp_latency: got %0d cycles, required 1", last_resp_cyc - last_in_cyc);
    end
  endtask

  task automatic test_idle_fragment();
    // Head of a packet arrives while idle; its tail (which looks like a valid
    // read response) arrives after the request went out and must be drained.
    send_pkt(1, 1'b0, 16'hAAAA, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    do_request(1'b0, 16'h0005, 16'h0050, 16'h0);
    push_resp(1'b1, 1'b0, 1'b0, 16'h0077);
    wait_tx(20);
    send_pkt(4, 1'b1, ID, 16'h0005, 16'h2000, 16'h1234, 16'h0, 16'h0);
    send_pkt(4, 1'b1, ID, 16'h0005, 16'h2000, 16'h0077, 16'h0, 16'h0);
    wait_resp(10);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      logic        wr;
      logic [15:0] dst;
      logic [15:0] a;
      logic [15:0] d;
      wr  = 1'($urandom_range(0, 1));
      dst = 16'($urandom_range(2, 200));
      a   = 16'($urandom_range(0, 65535));
      d   = 16'($urandom_range(0, 65535));
      do_request(wr, dst, a, d);
      wait_tx(20);
      if (wr) begin
        push_resp(1'b0, 1'b0, 1'b0, 16'h0);
        send_pkt(3, 1'b1, ID, dst, 16'h3400, 16'h0, 16'h0, 16'h0);
      end else begin
        push_resp(1'b1, 1'b0, 1'b0, d);
        send_pkt(4, 1'b1, ID, dst, 16'h2000, d, 16'h0, 16'h0);
      end
      wait_resp(10);
    end
  endtask

  task automatic test_no_response();
`ifdef OSD_REGACCESS_MASTER_TIMEOUT_EN
    push_resp(1'b0, 1'b1, 1'b1, 16'h0);
    do_request(1'b0, 16'h0005, 16'h0060, 16'h0);
    wait_tx(20);
    wait_resp(40);
    n_cmp++;
    if (last_resp_cyc - last_tx_cyc !== 16) begin
      n_bad++;
      $display("FAIL timeout_latency: got %0d cycles, required 16", last_resp_cyc - last_tx_cyc);
    end
    // A late response must be swallowed by the idle drain.
    send_pkt(4, 1'b1, ID, 16'h0005, 16'h2000, 16'h9999, 16'h0, 16'h0);
    repeat (3) tick();
`else
    int base;
    do_request(1'b0, 16'h0005, 16'h0060, 16'h0);
    wait_tx(20);
    base = resp_seen;
    repeat (1000) tick();
    n_cmp++;
    if (resp_seen !== base || dbg_state !== 4'd6) begin
      n_bad++;
      $display("FAIL no_timeout: got %0d completions state=%0d, required 0 completions state=6",
               resp_seen - base, dbg_state);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
`endif
  endtask

  task automatic test_rst_mid();
    int g = 0;
    int base;
    base = resp_seen;
    do_request(1'b1, 16'h0005, 16'h0070, 16'h4242);
    while (dbg_state !== 4'd3 && g < 10) begin
      tick();
      g++;
    end
    n_cmp++;
    if (dbg_state !== 4'd3) begin
      n_bad++;
      $display("FAIL rst_mid_reach: got state %0d, required 3", dbg_state);
    end
    rst = 1'b1;
    tick();
    tx_exp_q.delete();
    n_cmp++;
    if (dbg_state !== 4'd0 || debug_out.valid !== 1'b0 || req_ready !== 1'b0 || resp_rdata !== 16'h0) begin
      n_bad++;
      $display("FAIL rst_mid_abort: got state=%0d out_valid=%b req_ready=%b rdata=%h, required 0 0 0 0",
               dbg_state, debug_out.valid, req_ready, resp_rdata);
    end
    rst = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (req_ready !== 1'b1 || debug_out.valid !== 1'b0 || resp_seen !== base) begin
      n_bad++;
      $display("FAIL rst_mid_after: got req_ready=%b out_valid=%b completions=%0d, required 1 0 0",
               req_ready, debug_out.valid, resp_seen - base);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_read_err();
    test_stall();
    test_foreign();
    test_early_last();
    test_long_resp();
    test_idle_fragment();
    test_back_to_back();
    test_no_response();
    test_rst_mid();
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
